// File: rtl/trig_prbs_pkg.sv
// PRBS31 checker shared constants, state encoding and word predictor.
// Optional first-error capture in the top is enabled by TRIG_PRBS_FIRST_ERR_EN.
package trig_prbs_pkg;

  localparam int PRBS_LEN = 31;
  localparam int PRBS_TAP = 3;

  localparam logic [0:0] SEARCH = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  // b[n+31] = b[n] ^ b[n+3]; h[0] is the oldest bit, so up to 28 bits come from h alone
  function automatic logic [27:0] predict(input logic [PRBS_LEN-1:0] h);
    logic [27:0] p;
    for (int k = 0; k < 28; k++) begin
      p[k] = h[k] ^ h[k+PRBS_TAP];
    end
    return p;
  endfunction

endpackage

// File: rtl/prbs31_word_step.sv
// Combinational PRBS31 word step: predicted next bits and next 31-bit state.
// follow=1 shifts in the observed word instead of the prediction.
module prbs31_word_step
  import trig_prbs_pkg::*;
#(
  parameter int WORDWIDTH = 16
) (
  input  logic [PRBS_LEN-1:0]  state,
  input  logic                 follow,
  input  logic [WORDWIDTH-1:0] word,
  output logic [WORDWIDTH-1:0] bits,
  output logic [PRBS_LEN-1:0]  next_state
);

  logic [WORDWIDTH-1:0] shift_in;

  assign bits       = WORDWIDTH'(predict(state));
  assign shift_in   = follow ? word : bits;
  assign next_state = {shift_in, state[PRBS_LEN-1:WORDWIDTH]};

endmodule

// File: rtl/trig_prbs31_checker.sv
// Receive-side PRBS31 checker with self-sync search and free-running reference.
// Define TRIG_PRBS_FIRST_ERR_EN to add BCID/mask capture of the first error.
module trig_prbs31_checker
  import trig_prbs_pkg::*;
#(
  parameter int WORDWIDTH   = 16,
  parameter int LOCKWORDS   = 8,
  parameter int UNLOCKWORDS = 4,
  parameter int CNTWIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dis,
  input  logic                 dataValid,
  input  logic [WORDWIDTH-1:0] dataIn,
  input  logic                 clrCnt,
`ifdef TRIG_PRBS_FIRST_ERR_EN
  input  logic [11:0]          BCID,
  output logic                 firstErrValid,
  output logic [11:0]          firstErrBCID,
  output logic [WORDWIDTH-1:0] firstErrMask,
`endif
  output logic                 locked,
  output logic                 errFlag,
  output logic [CNTWIDTH-1:0]  errBitCount,
  output logic [CNTWIDTH-1:0]  errWordCount,
  output logic [CNTWIDTH-1:0]  checkedWordCount
);

  localparam int PW = $clog2(WORDWIDTH + 1);
  localparam int GW = $clog2(LOCKWORDS + 1);
  localparam int BW = $clog2(UNLOCKWORDS + 1);

  logic [0:0]           state;
  logic [PRBS_LEN-1:0]  hist;
  logic [PRBS_LEN-1:0]  ref_st;
  logic [PRBS_LEN-1:0]  hist_nxt;
  logic [PRBS_LEN-1:0]  ref_nxt;
  logic [WORDWIDTH-1:0] self_pred;
  logic [WORDWIDTH-1:0] ref_bits;
  logic [WORDWIDTH-1:0] err_self;
  logic [WORDWIDTH-1:0] err;
  logic [4:0]           fill;
  logic [4:0]           fill_nxt;
  logic [5:0]           fill_sum;
  logic [GW-1:0]        good_run;
  logic [BW-1:0]        bad_run;
  logic [PW-1:0]        pop;
  logic [CNTWIDTH:0]    bit_sum;
  logic                 accept;
  logic                 full;
  logic                 in_lock;

  prbs31_word_step #(.WORDWIDTH(WORDWIDTH)) u_search (
    .state      (hist),
    .follow     (1'b1),
    .word       (dataIn),
    .bits       (self_pred),
    .next_state (hist_nxt)
  );

  prbs31_word_step #(.WORDWIDTH(WORDWIDTH)) u_ref (
    .state      (ref_st),
    .follow     (1'b0),
    .word       (dataIn),
    .bits       (ref_bits),
    .next_state (ref_nxt)
  );

  assign accept   = dataValid & ~dis;
  assign in_lock  = (state == LOCKED);
  assign locked   = in_lock;
  assign full     = (fill == 5'd31);
  assign err_self = dataIn ^ self_pred;
  assign err      = dataIn ^ ref_bits;
  assign fill_sum = {1'b0, fill} + 6'(WORDWIDTH);
  assign fill_nxt = (fill_sum > 6'd31) ? 5'd31 : fill_sum[4:0];
  assign bit_sum  = {1'b0, errBitCount} + (CNTWIDTH+1)'(pop);

  always_comb begin
    pop = '0;
    for (int k = 0; k < WORDWIDTH; k++) begin
      pop = pop + PW'(err[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      errBitCount      <= '0;
      errWordCount     <= '0;
      checkedWordCount <= '0;
    end else if (clrCnt) begin
      errBitCount      <= '0;
      errWordCount     <= '0;
      checkedWordCount <= '0;
    end else if (accept && in_lock) begin
      if (checkedWordCount != '1) begin
        checkedWordCount <= checkedWordCount + CNTWIDTH'(1);
      end
      if (|err) begin
        if (errWordCount != '1) begin
          errWordCount <= errWordCount + CNTWIDTH'(1);
        end
        errBitCount <= bit_sum[CNTWIDTH] ? '1 : bit_sum[CNTWIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= SEARCH;
      hist     <= '0;
      ref_st   <= '0;
      fill     <= '0;
      good_run <= '0;
      bad_run  <= '0;
      errFlag  <= 1'b0;
    end else begin
      errFlag <= 1'b0;
      if (accept) begin
        hist <= hist_nxt;
        fill <= fill_nxt;
        if (!in_lock) begin
          if (full) begin
            if (err_self != '0) begin
              good_run <= '0;
            end else if (good_run == GW'(LOCKWORDS - 1)) begin
              state    <= LOCKED;
              ref_st   <= hist_nxt;
              good_run <= '0;
              bad_run  <= '0;
            end else begin
              good_run <= good_run + GW'(1);
            end
          end
        end else begin
          ref_st  <= ref_nxt;
          errFlag <= |err;
          if (err == '0) begin
            bad_run <= '0;
          end else if (bad_run == BW'(UNLOCKWORDS - 1)) begin
            state    <= SEARCH;
            good_run <= '0;
            bad_run  <= '0;
          end else begin
            bad_run <= bad_run + BW'(1);
          end
        end
      end else if (dis && in_lock) begin
        state    <= SEARCH;
        good_run <= '0;
        bad_run  <= '0;
      end
    end
  end

`ifdef TRIG_PRBS_FIRST_ERR_EN
  always_ff @(posedge clk) begin
    if (reset || clrCnt) begin
      firstErrValid <= 1'b0;
      firstErrBCID  <= '0;
      firstErrMask  <= '0;
    end else if (accept && in_lock && |err && !firstErrValid) begin
      firstErrValid <= 1'b1;
      firstErrBCID  <= BCID;
      firstErrMask  <= err;
    end
  end
`endif

endmodule
